// File: rtl/regfile_mp_if.sv
// Bus bundle for the dual-read / dual-write register file: read and write
// ports plus the soft-clear handshake.
interface regfile_mp_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] read_addr0;
    logic [ADDR_W-1:0] read_addr1;
    logic [DATA_W-1:0] read_data0;
    logic [DATA_W-1:0] read_data1;
    logic [ADDR_W-1:0] write_addr0;
    logic [DATA_W-1:0] write_data0;
    logic              write_enable0;
    logic [ADDR_W-1:0] write_addr1;
    logic [DATA_W-1:0] write_data1;
    logic              write_enable1;
    logic              clear_req;
    logic              busy;
    logic              clear_done;

    modport master (
        output read_addr0, read_addr1,
        output write_addr0, write_data0, write_enable0,
        output write_addr1, write_data1, write_enable1,
        output clear_req,
        input  read_data0, read_data1, busy, clear_done
    );

    modport slave (
        input  read_addr0, read_addr1,
        input  write_addr0, write_data0, write_enable0,
        input  write_addr1, write_data1, write_enable1,
        input  clear_req,
        output read_data0, read_data1, busy, clear_done
    );
endinterface

// File: rtl/regfile_mp.sv
// Register file with two combinational read ports, two write ports (port 1 wins
// on collisions) and a one-register-per-cycle soft clear sweep.
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int ZERO_REG0 = 0
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int                DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              sweep_we;
    logic              wr_en0, wr_en1;
    logic [DATA_W-1:0] regs_q [DEPTH];

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG0 != 0) && (addr == '0);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // The counter stops at LAST and returns to 0, so a sweep never makes a second pass.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clear_req) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        sweep_we       = (state_q == SWEEP);
        bus.busy       = (state_q == SWEEP);
        bus.clear_done = done_q;
        wr_en0 = !sweep_we && bus.write_enable0 && !is_zero_reg(bus.write_addr0);
        wr_en1 = !sweep_we && bus.write_enable1 && !is_zero_reg(bus.write_addr1);
    end

    // Port 1 is assigned last so it wins when both ports hit the same address.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (sweep_we) begin
            regs_q[cnt_q] <= '0;
        end else begin
            if (wr_en0) begin
                regs_q[bus.write_addr0] <= bus.write_data0;
            end
            if (wr_en1) begin
                regs_q[bus.write_addr1] <= bus.write_data1;
            end
        end
    end

    always_comb begin
        bus.read_data0 = regs_q[bus.read_addr0];
        bus.read_data1 = regs_q[bus.read_addr1];
`ifdef REGFILE_BYPASS_EN
        if (wr_en0 && (bus.write_addr0 == bus.read_addr0)) bus.read_data0 = bus.write_data0;
        if (wr_en1 && (bus.write_addr1 == bus.read_addr0)) bus.read_data0 = bus.write_data1;
        if (wr_en0 && (bus.write_addr0 == bus.read_addr1)) bus.read_data1 = bus.write_data0;
        if (wr_en1 && (bus.write_addr1 == bus.read_addr1)) bus.read_data1 = bus.write_data1;
`endif
        if (is_zero_reg(bus.read_addr0)) bus.read_data0 = '0;
        if (is_zero_reg(bus.read_addr1)) bus.read_data1 = '0;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: vector table for read/write behaviour plus
// hand-written sequences for the soft clear sweep, mid-sweep reset and ZERO_REG0.
module tb_regfile_mp;
    localparam int DW = 8;
    localparam int AW = 4;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW)) bus_z ();

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG0(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG0(1)) dut_z (
        .clk (clk),
        .rst (rst),
        .bus (bus_z)
    );

    typedef struct {
        logic          we0;
        logic [AW-1:0] wa0;
        logic [DW-1:0] wd0;
        logic          we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [DW-1:0] exp0;
        logic [DW-1:0] exp1;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle_main();
        bus.write_enable0 = 1'b0; bus.write_addr0 = '0; bus.write_data0 = '0;
        bus.write_enable1 = 1'b0; bus.write_addr1 = '0; bus.write_data1 = '0;
        bus.clear_req = 1'b0;
    endtask

    task automatic idle_z();
        bus_z.write_enable0 = 1'b0; bus_z.write_addr0 = '0; bus_z.write_data0 = '0;
        bus_z.write_enable1 = 1'b0; bus_z.write_addr1 = '0; bus_z.write_data1 = '0;
        bus_z.clear_req = 1'b0; bus_z.read_addr0 = '0; bus_z.read_addr1 = '0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            bus.read_addr0 = AW'(a);
            bus.read_addr1 = AW'(15 - a);
            #1;
            chk({tag, "_rd0"}, bus.read_data0, 8'h00);
            chk({tag, "_rd1"}, bus.read_data1, 8'h00);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt, done_cnt, done_k;

        // {we0,wa0,wd0, we1,wa1,wd1, ra0,ra1, exp0,exp1}
        vecs[0] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 4'd2, 4'd3, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 4'd2, 8'hAA, 1'b1, 4'd3, 8'h55, 4'd2, 4'd3,
                    BYP ? 8'hAA : 8'h00, BYP ? 8'h55 : 8'h00};
        vecs[2] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 4'd2, 4'd3, 8'hAA, 8'h55};
        vecs[3] = '{1'b1, 4'd5, 8'h11, 1'b1, 4'd5, 8'h22, 4'd5, 4'd2,
                    BYP ? 8'h22 : 8'h00, 8'hAA};
        vecs[4] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 4'd5, 4'd3, 8'h22, 8'h55};
        vecs[5] = '{1'b1, 4'd7, 8'h3C, 1'b1, 4'd8, 8'hC3, 4'd7, 4'd8,
                    BYP ? 8'h3C : 8'h00, BYP ? 8'hC3 : 8'h00};
        vecs[6] = '{1'b1, 4'd7, 8'h99, 1'b0, 4'd0, 8'h00, 4'd7, 4'd8,
                    BYP ? 8'h99 : 8'h3C, 8'hC3};
        vecs[7] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 4'd7, 4'd15, 8'h99, 8'h00};
        vecs[8] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd15, 8'h5A, 4'd15, 4'd15,
                    BYP ? 8'h5A : 8'h00, BYP ? 8'h5A : 8'h00};
        vecs[9] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 4'd15, 4'd0, 8'h5A, 8'h00};

        idle_main();
        idle_z();
        bus.read_addr0 = '0;
        bus.read_addr1 = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_busy", {7'b0, bus.busy}, 8'h00);
        chk("reset_done", {7'b0, bus.clear_done}, 8'h00);
        check_all_zero("reset");

        // Table-driven read/write vectors; reads checked in the write cycle.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.write_enable0 = vecs[i].we0; bus.write_addr0 = vecs[i].wa0; bus.write_data0 = vecs[i].wd0;
            bus.write_enable1 = vecs[i].we1; bus.write_addr1 = vecs[i].wa1; bus.write_data1 = vecs[i].wd1;
            bus.read_addr0 = vecs[i].ra0;
            bus.read_addr1 = vecs[i].ra1;
            #1;
            chk($sformatf("vec%0d_rd0", i), bus.read_data0, vecs[i].exp0);
            chk($sformatf("vec%0d_rd1", i), bus.read_data1, vecs[i].exp1);
        end

        // Fill with FF, then clear_req together with a write of 12 to reg 15.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.write_enable0 = 1'b1; bus.write_addr0 = AW'(2 * i);     bus.write_data0 = 8'hFF;
            bus.write_enable1 = 1'b1; bus.write_addr1 = AW'(2 * i + 1); bus.write_data1 = 8'hFF;
        end
        @(negedge clk);
        idle_main();
        bus.clear_req = 1'b1;
        bus.write_enable0 = 1'b1; bus.write_addr0 = 4'd15; bus.write_data0 = 8'h12;
        busy_cnt = 0;
        done_cnt = 0;
        done_k   = -1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            idle_main();
            bus.read_addr0 = 4'd9;
            bus.read_addr1 = 4'd15;
            if (k == 5)  bus.clear_req = 1'b1;
            if (k == 3 || k == 12) begin
                bus.write_enable0 = 1'b1; bus.write_addr0 = 4'd9; bus.write_data0 = 8'h77;
            end
            #1;
            if (bus.busy) busy_cnt++;
            if (bus.clear_done) begin
                done_cnt++;
                done_k = k;
            end
            if (k == 0) begin
                chk("sweep_start_busy", {7'b0, bus.busy}, 8'h01);
                chk("same_cycle_write_kept", bus.read_data1, 8'h12);
            end
            if (k == 3)  chk("busy_write_no_effect", bus.read_data0, 8'hFF);
            if (k == 12) chk("busy_write_no_bypass", bus.read_data0, 8'h00);
        end
        idle_main();
        chk("sweep_busy_cycles", 8'(busy_cnt), 8'd16);
        chk("sweep_done_pulses", 8'(done_cnt), 8'd1);
        chk("sweep_done_cycle", 8'(done_k), 8'd16);
        check_all_zero("sweep");

        // Reset in the cycle the sweep counter is 7, alongside a write and clear_req.
        @(negedge clk);
        bus.write_enable0 = 1'b1; bus.write_addr0 = 4'd14; bus.write_data0 = 8'hFF;
        bus.write_enable1 = 1'b1; bus.write_addr1 = 4'd15; bus.write_data1 = 8'hFF;
        @(negedge clk);
        idle_main();
        bus.clear_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            idle_main();
            if (k == 7) begin
                rst = 1'b1;
                bus.clear_req = 1'b1;
                bus.write_enable0 = 1'b1; bus.write_addr0 = 4'd3; bus.write_data0 = 8'h44;
            end
        end
        @(negedge clk);
        rst = 1'b0;
        idle_main();
        #1;
        chk("midrst_busy", {7'b0, bus.busy}, 8'h00);
        chk("midrst_done", {7'b0, bus.clear_done}, 8'h00);
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            if (bus.clear_done || bus.busy) done_cnt++;
        end
        chk("midrst_quiet", 8'(done_cnt), 8'd0);
        check_all_zero("midrst");

        // ZERO_REG0 instance: address 0 reads zero even in the write cycle.
        @(negedge clk);
        bus_z.write_enable0 = 1'b1; bus_z.write_addr0 = 4'd0; bus_z.write_data0 = 8'hC3;
        bus_z.write_enable1 = 1'b1; bus_z.write_addr1 = 4'd1; bus_z.write_data1 = 8'h4D;
        bus_z.read_addr0 = 4'd0;
        bus_z.read_addr1 = 4'd1;
        #1;
        chk("z0_write_cycle", bus_z.read_data0, 8'h00);
        chk("z0_other_bypass", bus_z.read_data1, BYP ? 8'h4D : 8'h00);
        @(negedge clk);
        bus_z.write_enable0 = 1'b0;
        bus_z.write_enable1 = 1'b1; bus_z.write_addr1 = 4'd0; bus_z.write_data1 = 8'hC3;
        #1;
        chk("z0_after_write", bus_z.read_data0, 8'h00);
        chk("z0_other_stored", bus_z.read_data1, 8'h4D);
        @(negedge clk);
        idle_z();
        #1;
        chk("z0_port1_write", bus_z.read_data0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
